caliptra_apb_initiator: RTL



---
 rtl/caliptra_apb_initiator_if.sv | 27 ++
 rtl/caliptra_apb_initiator.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/caliptra_apb_initiator_if.sv
// APB bus between the Caliptra APB initiator (master) and the Caliptra APB slave port (slave).
interface caliptra_apb_initiator_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned USER_W = 32
);
  logic [ADDR_W-1:0] PADDR;
  logic [USER_W-1:0] PAUSER;
  logic [DATA_W-1:0] PWDATA;
  logic              PWRITE;
  logic [2:0]        PPROT;
  logic              PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PAUSER, PWDATA, PWRITE, PPROT, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PAUSER, PWDATA, PWRITE, PPROT, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/caliptra_apb_initiator.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS transfer, response out.
// Define CALIPTRA_APB_INIT_TIMEOUT_EN to compile in the ACCESS wait-state timeout.
module caliptra_apb_initiator #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned USER_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 core_clk,
  input  logic                 cptra_rst_b,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [USER_W-1:0]    req_user,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_slverr,
  output logic                 rsp_timeout,
  output logic                 busy,
  caliptra_apb_initiator_if.master apb
);

  if (TIMEOUT_CYCLES < 1) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [USER_W-1:0] pauser_q, pauser_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              slverr_q, slverr_d;

`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
  localparam int unsigned       CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0]   CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            cnt_expired;

  // Expires on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign cnt_expired = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StSetup) begin
      cnt_d = '0;
    end else if (state_q == StAccess && !apb.PREADY) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pauser_d = pauser_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pauser_d = req_user;
          pwrite_d = req_write;
          pwdata_d = req_write ? req_wdata : '0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        // A completing PREADY always wins over an expiring timeout.
        if (apb.PREADY) begin
          rdata_d  = pwrite_q ? '0 : apb.PRDATA;
          slverr_d = apb.PSLVERR;
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d  = StResp;
        end
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
        else if (cnt_expired) begin
          rdata_d   = '0;
          slverr_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = StResp;
        end
`endif
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pauser_q <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pauser_q <= pauser_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
    end
  end

  // PSEL/PENABLE decode straight from state so reset drops them without a clock edge.
  assign apb.PSEL    = (state_q == StSetup) || (state_q == StAccess);
  assign apb.PENABLE = (state_q == StAccess);
  assign apb.PADDR   = paddr_q;
  assign apb.PAUSER  = pauser_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PPROT   = 3'b000;

  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp);
  assign rsp_rdata  = rdata_q;
  assign rsp_slverr = slverr_q;
  assign busy       = (state_q != StIdle);

endmodule
